demux4_route_32: RTL and testbench

DEMUX4_ROUTE_32 -- requirements
Module: demux4_route_32

---
 rtl/demux4_route_32.sv | 121 ++++++++++++
 tb/tb_demux4_route_32.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/demux4_route_32.sv
// 1-to-4 ready/valid demultiplexer with an output register plus one-entry skid buffer.
// Optional per-destination 8-bit transfer counters on out_cnt when DEMUX_COUNT_EN is defined.
module demux4_route_32 #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [1:0]        in_sel,
  output logic [3:0]        out_valid,
  input  logic [3:0]        out_ready,
  output logic [DATA_W-1:0] out_data
`ifdef DEMUX_COUNT_EN
  ,
  output logic [31:0]       out_cnt
`endif
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    SKID  = 2'd2
  } state_t;

  state_t            state_q;
  logic              in_ready_q;
  logic [3:0]        out_valid_q;
  logic [DATA_W-1:0] or_data_q;
  logic [DATA_W-1:0] sb_data_q;
  logic [1:0]        sb_sel_q;

  logic in_xfer;
  logic out_xfer;

  function automatic logic [3:0] onehot(input logic [1:0] s);
    return 4'b0001 << s;
  endfunction

  // out_valid is held one-hot, so masking with out_ready ignores non-selected destinations
  assign in_xfer  = in_valid & in_ready_q;
  assign out_xfer = |(out_valid_q & out_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 4'b0000;
      or_data_q   <= '0;
      sb_data_q   <= '0;
      sb_sel_q    <= 2'd0;
    end else begin
      case (state_q)
        EMPTY: begin
          if (in_xfer) begin
            or_data_q   <= in_data;
            out_valid_q <= onehot(in_sel);
            state_q     <= FULL;
          end
        end
        FULL: begin
          if (in_xfer && out_xfer) begin
            or_data_q   <= in_data;
            out_valid_q <= onehot(in_sel);
          end else if (out_xfer) begin
            out_valid_q <= 4'b0000;
            state_q     <= EMPTY;
          end else if (in_xfer) begin
            sb_data_q  <= in_data;
            sb_sel_q   <= in_sel;
            in_ready_q <= 1'b0;
            state_q    <= SKID;
          end
        end
        SKID: begin
          if (out_xfer) begin
            or_data_q   <= sb_data_q;
            out_valid_q <= onehot(sb_sel_q);
            in_ready_q  <= 1'b1;
            state_q     <= FULL;
          end
        end
        default: begin
          state_q     <= EMPTY;
          in_ready_q  <= 1'b1;
          out_valid_q <= 4'b0000;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = or_data_q;

`ifdef DEMUX_COUNT_EN
  logic [31:0] cnt_q;
  logic [31:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    for (int k = 0; k < 4; k++) begin
      if (out_valid_q[k] && out_ready[k]) begin
        cnt_d[8*k +: 8] = cnt_q[8*k +: 8] + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign out_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_demux4_route_32.sv
// Directed and scoreboard-checked bench for demux4_route_32 (counter test active with DEMUX_COUNT_EN).
module tb_demux4_route_32;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [1:0]  in_sel;
  logic [3:0]  out_valid;
  logic [3:0]  out_ready;
  logic [31:0] out_data;
`ifdef DEMUX_COUNT_EN
  logic [31:0] out_cnt;
`endif

  int n_cmp;
  int n_bad;

  demux4_route_32 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
`ifdef DEMUX_COUNT_EN
    .out_cnt   (out_cnt),
`endif
    .out_data  (out_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_data = 32'h0; in_sel = 2'd0; out_ready = 4'h0;
    #12;
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    n_cmp++; if (out_valid !== 4'b0000) begin n_bad++; $display("FAIL reset_out_valid: got %b expected 0000", out_valid); end
    n_cmp++; if (out_data !== 32'h0) begin n_bad++; $display("FAIL reset_out_data: got %h expected 00000000", out_data); end
`ifdef DEMUX_COUNT_EN
    n_cmp++; if (out_cnt !== 32'h0) begin n_bad++; $display("FAIL reset_out_cnt: got %h expected 00000000", out_cnt); end
`endif
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_stream();
    out_ready = 4'hF;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = 32'hA000_0000 + i; in_sel = 2'(i);
      step();
      n_cmp++; if (out_valid !== (4'b0001 << i)) begin n_bad++; $display("FAIL stream_valid[%0d]: got %b expected %b", i, out_valid, 4'b0001 << i); end
      n_cmp++; if (out_data !== 32'hA000_0000 + i) begin n_bad++; $display("FAIL stream_data[%0d]: got %h expected %h", i, out_data, 32'hA000_0000 + i); end
      n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL stream_ready[%0d]: got %b expected 1", i, in_ready); end
    end
    in_valid = 1'b0;
    step();
    n_cmp++; if (out_valid !== 4'b0000) begin n_bad++; $display("FAIL stream_drain: got %b expected 0000", out_valid); end
  endtask

  task automatic test_backpressure();
    out_ready = 4'h0;
    in_valid = 1'b1; in_sel = 2'd2; in_data = 32'hB000_0001;
    step();
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL bp_ready1: got %b expected 1", in_ready); end
    in_data = 32'hB000_0002;
    step();
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_ready2: got %b expected 0", in_ready); end
    in_data = 32'hB000_0003;
    step();
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_wait: got %b expected 0", in_ready); end
    n_cmp++; if (out_data !== 32'hB000_0001 || out_valid !== 4'b0100) begin n_bad++; $display("FAIL bp_hold: got %h/%b expected b0000001/0100", out_data, out_valid); end
    out_ready = 4'b0100;
    step();
    n_cmp++; if (out_data !== 32'hB000_0002 || in_ready !== 1'b1) begin n_bad++; $display("FAIL bp_word2: got %h/%b expected b0000002/1", out_data, in_ready); end
    step();
    n_cmp++; if (out_data !== 32'hB000_0003 || out_valid !== 4'b0100) begin n_bad++; $display("FAIL bp_word3: got %h/%b expected b0000003/0100", out_data, out_valid); end
    in_valid = 1'b0;
    step();
    n_cmp++; if (out_valid !== 4'b0000) begin n_bad++; $display("FAIL bp_drain: got %b expected 0000", out_valid); end
  endtask

  task automatic test_ignored_ready();
    out_ready = 4'h0;
    in_valid = 1'b1; in_sel = 2'd1; in_data = 32'hC000_0001;
    step();
    in_valid = 1'b0; out_ready = 4'b1101;
    step();
    step();
    n_cmp++; if (out_valid !== 4'b0010) begin n_bad++; $display("FAIL ign_valid: got %b expected 0010", out_valid); end
    n_cmp++; if (out_data !== 32'hC000_0001) begin n_bad++; $display("FAIL ign_data: got %h expected c0000001", out_data); end
    out_ready = 4'b0010;
    step();
    n_cmp++; if (out_valid !== 4'b0000) begin n_bad++; $display("FAIL ign_xfer: got %b expected 0000", out_valid); end
  endtask

  task automatic test_reset_mid();
    out_ready = 4'h0;
    in_valid = 1'b1; in_sel = 2'd0; in_data = 32'hD000_0001;
    step();
    in_data = 32'hD000_0002;
    step();
    in_valid = 1'b0;
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL rstmid_skid: got %b expected 0", in_ready); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 4'b0000 || out_data !== 32'h0 || in_ready !== 1'b1) begin
      n_bad++; $display("FAIL rstmid_async: got %b/%h/%b expected 0000/00000000/1", out_valid, out_data, in_ready);
    end
    #1 rst_n = 1'b1;
    out_ready = 4'hF;
    for (int i = 0; i < 3; i++) begin
      step();
      n_cmp++; if (out_valid !== 4'b0000) begin n_bad++; $display("FAIL rstmid_nodeliver[%0d]: got %b expected 0000", i, out_valid); end
    end
  endtask

`ifdef DEMUX_COUNT_EN
  task automatic test_counters();
    out_ready = 4'hF;
    in_valid = 1'b1; in_sel = 2'd3;
    for (int i = 0; i < 257; i++) begin
      in_data = i;
      step();
    end
    in_valid = 1'b0;
    step();
    n_cmp++; if (out_cnt !== 32'h0100_0000) begin n_bad++; $display("FAIL cnt_wrap: got %h expected 01000000", out_cnt); end
  endtask
`endif

  task automatic test_random();
    logic [33:0] q[$];
    logic [33:0] head;
    for (int c = 0; c < 10000; c++) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_sel    = 2'($urandom_range(0, 3));
      in_data   = $urandom;
      out_ready = 4'($urandom_range(0, 15));
      @(negedge clk);
      n_cmp++; if (in_ready !== (q.size() < 2)) begin n_bad++; $display("FAIL rnd_ready[%0d]: got %b expected %b", c, in_ready, q.size() < 2); end
      n_cmp++; if (!(out_valid inside {4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000})) begin n_bad++; $display("FAIL rnd_onehot[%0d]: got %b expected one-hot or 0000", c, out_valid); end
      if (q.size() == 0) begin
        n_cmp++; if (out_valid !== 4'b0000) begin n_bad++; $display("FAIL rnd_spurious[%0d]: got %b expected 0000", c, out_valid); end
      end else begin
        head = q[0];
        n_cmp++; if (out_valid !== (4'b0001 << head[1:0]) || out_data !== head[33:2]) begin
          n_bad++; $display("FAIL rnd_word[%0d]: got %b/%h expected %b/%h", c, out_valid, out_data, 4'b0001 << head[1:0], head[33:2]);
        end
        if (|(out_valid & out_ready)) void'(q.pop_front());
      end
      if (in_valid && in_ready) q.push_back({in_data, in_sel});
      step();
    end
    in_valid = 1'b0; out_ready = 4'hF;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (|(out_valid & out_ready) && q.size() > 0) void'(q.pop_front());
      step();
    end
    n_cmp++; if (q.size() != 0 || out_valid !== 4'b0000) begin n_bad++; $display("FAIL rnd_drain: got %0d queued/%b expected 0/0000", q.size(), out_valid); end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_stream();
    test_backpressure();
    test_ignored_ready();
    test_reset_mid();
`ifdef DEMUX_COUNT_EN
    test_counters();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
